// File: rtl/ft245_bridge_pkg.sv
// Shared types and constants for the FT245 byte-FIFO to register-bus bridge.
package ft245_bridge_pkg;

  localparam int CMD_READ_BIT = 7;
  localparam int CMD_LEN_MSB  = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_CMD,
    S_GET_ADDR,
    S_GET_DATA,
    S_BUS_WR,
    S_BUS_RD,
    S_WAIT_RD,
    S_SEND_DATA
  } main_state_e;

  typedef enum logic [2:0] {
    B_IDLE,
    B_RD,
    B_WSET,
    B_WR,
    B_WHOLD,
    B_GAP
  } byte_state_e;

  // Width of a counter that must hold the values 0 .. n-1.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ft245_byte_if.sv
// FT245 pin-level engine: synchronises RXF#/TXE#, times the RD#/WR strobes and
// hands single bytes to and from the packet FSM through a req/done handshake.
module ft245_byte_if
  import ft245_bridge_pkg::*;
#(
  parameter int RD_PULSE = 3,
  parameter int WR_PULSE = 2,
  parameter int GAP_CYC  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       FT_RXFn,
  input  logic       FT_TXEn,
  input  logic [7:0] FT_DATA_In,
  input  logic       rd_req,
  input  logic       wr_req,
  input  logic [7:0] wr_byte,
  output logic       rd_start,
  output logic       rd_done,
  output logic [7:0] rd_byte,
  output logic       wr_done,
  output logic       FT_RDn,
  output logic       FT_WR,
  output logic [7:0] FT_DATA_Out,
  output logic       FT_DATA_OE
);

  localparam int MAX_RW = (RD_PULSE > WR_PULSE) ? RD_PULSE : WR_PULSE;
  localparam int MAXC   = (MAX_RW > GAP_CYC) ? MAX_RW : GAP_CYC;
  localparam int CW     = cnt_w(MAXC);
  localparam logic [CW-1:0] RD_LAST  = CW'(RD_PULSE - 1);
  localparam logic [CW-1:0] WR_LAST  = CW'(WR_PULSE - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

  byte_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    rxf_q, txe_q;
  logic          rdn_q, rdn_d, wr_q, wr_d, oe_q, oe_d;
  logic [7:0]    dout_q, dout_d, rd_byte_q, rd_byte_d;
  logic          rd_done_q, rd_done_d, wr_done_q, wr_done_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    rd_byte_d = rd_byte_q;
    rd_done_d = 1'b0;
    wr_done_d = 1'b0;
    rd_start  = 1'b0;
    unique case (state_q)
      B_IDLE: begin
        if (rd_req && !rxf_q[1]) begin
          state_d  = B_RD;
          cnt_d    = '0;
          rd_start = 1'b1;
        end else if (wr_req && !txe_q[1]) begin
          state_d = B_WSET;
          dout_d  = wr_byte;
        end
      end
      B_RD: begin
        // Capture at the edge that ends the last low cycle of RD#.
        if (cnt_q == RD_LAST) begin
          rd_byte_d = FT_DATA_In;
          rd_done_d = 1'b1;
          state_d   = B_GAP;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      B_WSET: begin
        state_d = B_WR;
        cnt_d   = '0;
      end
      B_WR: begin
        if (cnt_q == WR_LAST) state_d = B_WHOLD;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      B_WHOLD: begin
        wr_done_d = 1'b1;
        state_d   = B_GAP;
        cnt_d     = '0;
      end
      B_GAP: begin
        if (cnt_q == GAP_LAST) state_d = B_IDLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = B_IDLE;
    endcase
    rdn_d = (state_d != B_RD);
    wr_d  = (state_d == B_WR);
    oe_d  = (state_d == B_WSET) || (state_d == B_WR) || (state_d == B_WHOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= B_IDLE;
      cnt_q     <= '0;
      rxf_q     <= 2'b11;
      txe_q     <= 2'b11;
      rdn_q     <= 1'b1;
      wr_q      <= 1'b0;
      oe_q      <= 1'b0;
      dout_q    <= '0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rxf_q     <= {rxf_q[0], FT_RXFn};
      txe_q     <= {txe_q[0], FT_TXEn};
      rdn_q     <= rdn_d;
      wr_q      <= wr_d;
      oe_q      <= oe_d;
      dout_q    <= dout_d;
      rd_done_q <= rd_done_d;
      wr_done_q <= wr_done_d;
    end
  end

  always_ff @(posedge clk) rd_byte_q <= rd_byte_d;

  assign FT_RDn      = rdn_q;
  assign FT_WR       = wr_q;
  assign FT_DATA_OE  = oe_q;
  assign FT_DATA_Out = dout_q;
  assign rd_done     = rd_done_q;
  assign rd_byte     = rd_byte_q;
  assign wr_done     = wr_done_q;

endmodule

// File: rtl/ft245_reg_bridge.sv
// Packet decoder turning FT245 byte streams into burst register writes/reads
// with auto-incrementing address and an inter-byte timeout.
module ft245_reg_bridge
  import ft245_bridge_pkg::*;
#(
  parameter int ADDR_BYTES  = 2,
  parameter int DATA_BYTES  = 2,
  parameter int RD_PULSE    = 3,
  parameter int WR_PULSE    = 2,
  parameter int GAP_CYC     = 2,
  parameter int READ_LAT    = 1,
  parameter int TIMEOUT_CYC = 25000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    FT_RXFn,
  input  logic                    FT_TXEn,
  input  logic [7:0]              FT_DATA_In,
  output logic                    FT_RDn,
  output logic                    FT_WR,
  output logic [7:0]              FT_DATA_Out,
  output logic                    FT_DATA_OE,
  output logic [8*ADDR_BYTES-1:0] reg_addr,
  output logic [8*DATA_BYTES-1:0] reg_wdata,
  output logic                    reg_we,
  output logic                    reg_re,
  input  logic [8*DATA_BYTES-1:0] reg_rdata,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int AW   = 8 * ADDR_BYTES;
  localparam int DW   = 8 * DATA_BYTES;
  localparam int MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int BW   = cnt_w(MAXB);
  localparam int LW   = cnt_w(READ_LAT);
  localparam int TW   = cnt_w(TIMEOUT_CYC);
  localparam logic [BW-1:0] A_LAST   = BW'(ADDR_BYTES - 1);
  localparam logic [BW-1:0] D_LAST   = BW'(DATA_BYTES - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(READ_LAT - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  main_state_e   state_q, state_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [6:0]    wcnt_q, wcnt_d;
  logic          is_rd_q, is_rd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rbuf_q, rbuf_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          we_q, re_q, busy_q, tmo_err_q, tmo_hit;
  logic          rd_req, wr_req, rd_start, rd_done, wr_done;
  logic [7:0]    rd_byte, wr_byte;

  ft245_byte_if #(
    .RD_PULSE(RD_PULSE),
    .WR_PULSE(WR_PULSE),
    .GAP_CYC (GAP_CYC)
  ) u_byte_if (
    .clk        (clk),
    .rst        (rst),
    .FT_RXFn    (FT_RXFn),
    .FT_TXEn    (FT_TXEn),
    .FT_DATA_In (FT_DATA_In),
    .rd_req     (rd_req),
    .wr_req     (wr_req),
    .wr_byte    (wr_byte),
    .rd_start   (rd_start),
    .rd_done    (rd_done),
    .rd_byte    (rd_byte),
    .wr_done    (wr_done),
    .FT_RDn     (FT_RDn),
    .FT_WR      (FT_WR),
    .FT_DATA_Out(FT_DATA_Out),
    .FT_DATA_OE (FT_DATA_OE)
  );

  always_comb begin
    wr_byte = '0;
    for (int i = 0; i < DATA_BYTES; i++)
      if (bcnt_q == BW'(i)) wr_byte = rbuf_q[i*8 +: 8];
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    wcnt_d  = wcnt_q;
    is_rd_d = is_rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    lat_d   = lat_q;
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    tmo_hit = (state_q != S_IDLE) && (tmo_q == TMO_LAST);
    tmo_d   = (state_q == S_IDLE || rd_done || wr_done) ? '0 : tmo_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        // The command byte strobe is the packet start.
        rd_req = 1'b1;
        if (rd_start) state_d = S_GET_CMD;
      end
      S_GET_CMD: begin
        if (rd_done) begin
          is_rd_d = rd_byte[CMD_READ_BIT];
          wcnt_d  = rd_byte[CMD_LEN_MSB:0];
          bcnt_d  = '0;
          state_d = S_GET_ADDR;
        end
      end
      S_GET_ADDR: begin
        rd_req = 1'b1;
        if (rd_done) begin
          for (int i = 0; i < ADDR_BYTES; i++)
            if (bcnt_q == BW'(i)) addr_d[i*8 +: 8] = rd_byte;
          if (bcnt_q == A_LAST) begin
            bcnt_d  = '0;
            state_d = is_rd_q ? S_BUS_RD : S_GET_DATA;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      S_GET_DATA: begin
        rd_req = 1'b1;
        if (rd_done) begin
          for (int i = 0; i < DATA_BYTES; i++)
            if (bcnt_q == BW'(i)) wdata_d[i*8 +: 8] = rd_byte;
          if (bcnt_q == D_LAST) begin
            bcnt_d  = '0;
            state_d = S_BUS_WR;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      S_BUS_WR: begin
        addr_d = addr_q + 1'b1;
        if (wcnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          wcnt_d  = wcnt_q - 1'b1;
          state_d = S_GET_DATA;
        end
      end
      S_BUS_RD: begin
        lat_d   = '0;
        state_d = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        if (lat_q == LAT_LAST) begin
          rbuf_d  = reg_rdata;
          bcnt_d  = '0;
          state_d = S_SEND_DATA;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_SEND_DATA: begin
        wr_req = 1'b1;
        if (wr_done) begin
          if (bcnt_q == D_LAST) begin
            bcnt_d = '0;
            if (wcnt_q == '0) begin
              state_d = S_IDLE;
            end else begin
              wcnt_d  = wcnt_q - 1'b1;
              addr_d  = addr_q + 1'b1;
              state_d = S_BUS_RD;
            end
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort drops any partially assembled word; completed writes remain.
    if (tmo_hit) begin
      state_d = S_IDLE;
      bcnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bcnt_q    <= '0;
      wcnt_q    <= '0;
      is_rd_q   <= 1'b0;
      lat_q     <= '0;
      tmo_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      busy_q    <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      wcnt_q    <= wcnt_d;
      is_rd_q   <= is_rd_d;
      lat_q     <= lat_d;
      tmo_q     <= tmo_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= (state_d == S_BUS_WR);
      re_q      <= (state_d == S_BUS_RD);
      busy_q    <= (state_d != S_IDLE);
      tmo_err_q <= tmo_hit;
    end
  end

  always_ff @(posedge clk) rbuf_q <= rbuf_d;

  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;
  assign reg_we      = we_q;
  assign reg_re      = re_q;
  assign busy        = busy_q;
  assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_ft245_reg_bridge.sv
// Scoreboard bench for ft245_reg_bridge with an FT245 FIFO model and a register map model.
module tb_ft245_reg_bridge;

  localparam int TMO = 25000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        FT_RXFn = 1'b1;
  logic        FT_TXEn = 1'b0;
  logic [7:0]  FT_DATA_In = 8'h00;
  logic        FT_RDn, FT_WR, FT_DATA_OE;
  logic [7:0]  FT_DATA_Out;
  logic [15:0] reg_addr, reg_wdata;
  logic        reg_we, reg_re, busy, timeout_err;
  logic [15:0] reg_rdata = 16'h0000;

  always #5 clk = ~clk;

  ft245_reg_bridge #(
    .ADDR_BYTES(2), .DATA_BYTES(2), .RD_PULSE(3), .WR_PULSE(2),
    .GAP_CYC(2), .READ_LAT(1), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .FT_RXFn(FT_RXFn), .FT_TXEn(FT_TXEn),
    .FT_DATA_In(FT_DATA_In), .FT_RDn(FT_RDn), .FT_WR(FT_WR),
    .FT_DATA_Out(FT_DATA_Out), .FT_DATA_OE(FT_DATA_OE),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy),
    .timeout_err(timeout_err)
  );

  logic [7:0]  rx_q[$], exp_tx[$], got_tx[$];
  logic [31:0] exp_wr[$], got_wr[$];
  logic [15:0] mem [logic [15:0]];

  int n_tests = 0, n_fail = 0;
  int cycle = 0, rx_pop_time = 0, tmo_time = 0, tmo_pulses = 0, tmo_hi = 0;
  int busy_rises = 0, wr_rises = 0, wr_w = 0, last_wr_width = 0;
  int setup_bad = 0, proto_err = 0;
  logic       rdn_prev = 1'b1, wr_prev = 1'b0, oe_prev = 1'b0;
  logic       tmo_prev = 1'b0, busy_prev = 1'b0;
  logic [7:0] dout_prev = 8'h00;
  logic [46:0] rst_exp = 47'h4000_0000_0000;

  // FIFO pins, register map and observation, all sampled mid-cycle.
  always @(negedge clk) begin
    if (reg_we) begin
      got_wr.push_back({reg_addr, reg_wdata});
      mem[reg_addr] = reg_wdata;
    end
    if (timeout_err) tmo_hi++;
    if (timeout_err && !tmo_prev) begin
      tmo_pulses++;
      tmo_time = cycle;
    end
    if (busy && !busy_prev) busy_rises++;
    if (!FT_RDn && rx_q.size() > 0) FT_DATA_In = rx_q[0];
    if (FT_RDn && !rdn_prev && rx_q.size() > 0) begin
      void'(rx_q.pop_front());
      rx_pop_time = cycle;
    end
    FT_RXFn = (rx_q.size() == 0);
    if (FT_WR && !wr_prev) begin
      wr_rises++;
      wr_w = 0;
      if (!(oe_prev && dout_prev == FT_DATA_Out)) setup_bad++;
    end
    if (FT_WR) wr_w++;
    if (!FT_WR && wr_prev) begin
      got_tx.push_back(FT_DATA_Out);
      last_wr_width = wr_w;
      if (!FT_DATA_OE || FT_DATA_Out != dout_prev) setup_bad++;
    end
    if (!FT_RDn && (FT_WR || FT_DATA_OE)) proto_err++;
    rdn_prev  = FT_RDn;
    wr_prev   = FT_WR;
    oe_prev   = FT_DATA_OE;
    dout_prev = FT_DATA_Out;
    tmo_prev  = timeout_err;
    busy_prev = busy;
    cycle++;
  end

  always @(posedge clk)
    if (reg_re) reg_rdata <= mem.exists(reg_addr) ? mem[reg_addr] : 16'h0000;

  task automatic push_rx(input logic [7:0] b);
    rx_q.push_back(b);
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    int stable = 0;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (rx_q.size() == 0 && !busy) stable++;
      else stable = 0;
      if (stable >= 8) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({FT_RDn, FT_WR, FT_DATA_OE, FT_DATA_Out, reg_we, reg_re, reg_addr,
         reg_wdata, busy, timeout_err} !== rst_exp) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=%h", {FT_RDn, FT_WR, FT_DATA_OE,
               FT_DATA_Out, reg_we, reg_re, reg_addr, reg_wdata, busy, timeout_err}, rst_exp);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write_single();
    bit ok;
    logic [31:0] e, g;
    int b0 = busy_rises;
    push_rx(8'h00); push_rx(8'h34); push_rx(8'h12); push_rx(8'hCD); push_rx(8'hAB);
    exp_wr.push_back({16'h1234, 16'hABCD});
    wait_done(400, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL wr1_done got=%0d exp=1", ok); end
    n_tests++;
    if (got_wr.size() != 1) begin n_fail++; $display("FAIL wr1_count got=%0d exp=1", got_wr.size()); end
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      g = (got_wr.size() > 0) ? got_wr.pop_front() : 32'hDEAD_DEAD;
      n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL wr1_word got=%h exp=%h", g, e); end
    end
    got_wr.delete();
    n_tests++;
    if (busy_rises - b0 != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wr1_busy rises=%0d busy=%b exp rises=1 busy=0", busy_rises - b0, busy);
    end
  endtask

  task automatic test_burst_write();
    bit ok;
    logic [31:0] e, g;
    int n_exp;
    push_rx(8'h02); push_rx(8'hFF); push_rx(8'hFF);
    push_rx(8'h11); push_rx(8'h22); push_rx(8'h33);
    push_rx(8'h44); push_rx(8'h55); push_rx(8'h66);
    exp_wr.push_back({16'hFFFF, 16'h2211});
    exp_wr.push_back({16'h0000, 16'h4433});
    exp_wr.push_back({16'h0001, 16'h6655});
    n_exp = exp_wr.size();
    wait_done(800, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL burst_done got=%0d exp=1", ok); end
    n_tests++;
    if (got_wr.size() != n_exp) begin
      n_fail++; $display("FAIL burst_count got=%0d exp=%0d", got_wr.size(), n_exp);
    end
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      g = (got_wr.size() > 0) ? got_wr.pop_front() : 32'hDEAD_DEAD;
      n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL burst_word got=%h exp=%h", g, e); end
    end
    got_wr.delete();
  endtask

  task automatic test_read_burst();
    bit ok;
    logic [7:0] e, g;
    int n_exp;
    mem[16'h0010] = 16'h1111;
    mem[16'h0011] = 16'h2222;
    push_rx(8'h81); push_rx(8'h10); push_rx(8'h00);
    exp_tx.push_back(8'h11); exp_tx.push_back(8'h11);
    exp_tx.push_back(8'h22); exp_tx.push_back(8'h22);
    n_exp = exp_tx.size();
    wait_done(800, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rd_done got=%0d exp=1", ok); end
    n_tests++;
    if (got_tx.size() != n_exp) begin
      n_fail++; $display("FAIL rd_count got=%0d exp=%0d", got_tx.size(), n_exp);
    end
    while (exp_tx.size() > 0) begin
      e = exp_tx.pop_front();
      g = (got_tx.size() > 0) ? got_tx.pop_front() : 8'hXX;
      n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL rd_byte got=%h exp=%h", g, e); end
    end
    got_tx.delete();
    n_tests++;
    if (last_wr_width != 2) begin n_fail++; $display("FAIL rd_wr_width got=%0d exp=2", last_wr_width); end
    n_tests++;
    if (setup_bad != 0) begin n_fail++; $display("FAIL rd_setup_hold got=%0d exp=0", setup_bad); end
    n_tests++;
    if (got_wr.size() != 0) begin n_fail++; $display("FAIL rd_no_we got=%0d exp=0", got_wr.size()); end
  endtask

  task automatic test_txe_stall();
    bit ok;
    logic [7:0] e, g;
    int r0, n_exp;
    mem[16'h0200] = 16'hA55A;
    mem[16'h0201] = 16'h3CC3;
    FT_TXEn = 1'b1;
    push_rx(8'h81); push_rx(8'h00); push_rx(8'h02);
    exp_tx.push_back(8'h5A); exp_tx.push_back(8'hA5);
    exp_tx.push_back(8'hC3); exp_tx.push_back(8'h3C);
    n_exp = exp_tx.size();
    for (int i = 0; i < 300 && rx_q.size() > 0; i++) @(negedge clk);
    r0 = wr_rises;
    repeat (100) @(negedge clk);
    n_tests++;
    if (wr_rises != r0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL stall_hold wr_rises=%0d busy=%b exp 0 and 1", wr_rises - r0, busy);
    end
    FT_TXEn = 1'b0;
    wait_done(800, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL stall_done got=%0d exp=1", ok); end
    n_tests++;
    if (got_tx.size() != n_exp) begin
      n_fail++; $display("FAIL stall_count got=%0d exp=%0d", got_tx.size(), n_exp);
    end
    while (exp_tx.size() > 0) begin
      e = exp_tx.pop_front();
      g = (got_tx.size() > 0) ? got_tx.pop_front() : 8'hXX;
      n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL stall_byte got=%h exp=%h", g, e); end
    end
    got_tx.delete();
  endtask

  task automatic test_timeout();
    bit ok, seen;
    logic [31:0] e, g;
    int p0, el;
    p0 = tmo_pulses;
    tmo_hi = 0;
    seen = 1'b0;
    push_rx(8'h00); push_rx(8'h34);
    for (int i = 0; i < 300 && rx_q.size() > 0; i++) @(negedge clk);
    for (int i = 0; i < TMO + 200; i++) begin
      @(negedge clk);
      if (tmo_pulses != p0) begin
        seen = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk);
    el = tmo_time - rx_pop_time;
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL tmo_seen got=0 exp=1"); end
    n_tests++;
    if (el < TMO || el > TMO + 3) begin
      n_fail++; $display("FAIL tmo_latency got=%0d exp=%0d..%0d", el, TMO, TMO + 3);
    end
    n_tests++;
    if (tmo_hi != 1) begin n_fail++; $display("FAIL tmo_width got=%0d exp=1", tmo_hi); end
    n_tests++;
    if (got_wr.size() != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL tmo_state we=%0d busy=%b exp 0 and 0", got_wr.size(), busy);
    end
    push_rx(8'h00); push_rx(8'h55); push_rx(8'h00); push_rx(8'hEE); push_rx(8'h0B);
    exp_wr.push_back({16'h0055, 16'h0BEE});
    wait_done(400, ok);
    n_tests++;
    if (!ok || got_wr.size() != 1) begin
      n_fail++; $display("FAIL tmo_next_count got=%0d exp=1", got_wr.size());
    end
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      g = (got_wr.size() > 0) ? got_wr.pop_front() : 32'hDEAD_DEAD;
      n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL tmo_next_word got=%h exp=%h", g, e); end
    end
    got_wr.delete();
  endtask

  task automatic test_reset_mid_strobe();
    bit ok, low;
    logic [31:0] e, g;
    low = 1'b0;
    push_rx(8'h00);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!FT_RDn) begin
        low = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!low) begin n_fail++; $display("FAIL rstmid_strobe got=1 exp=0"); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if ({FT_RDn, FT_WR, FT_DATA_OE, FT_DATA_Out, reg_we, reg_re, reg_addr,
         reg_wdata, busy, timeout_err} !== rst_exp) begin
      n_fail++;
      $display("FAIL rstmid_outputs got=%h exp=%h", {FT_RDn, FT_WR, FT_DATA_OE,
               FT_DATA_Out, reg_we, reg_re, reg_addr, reg_wdata, busy, timeout_err}, rst_exp);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    push_rx(8'h00); push_rx(8'h77); push_rx(8'h00); push_rx(8'hEF); push_rx(8'hBE);
    exp_wr.push_back({16'h0077, 16'hBEEF});
    wait_done(400, ok);
    n_tests++;
    if (!ok || got_wr.size() != 1) begin
      n_fail++; $display("FAIL rstmid_count got=%0d exp=1", got_wr.size());
    end
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      g = (got_wr.size() > 0) ? got_wr.pop_front() : 32'hDEAD_DEAD;
      n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL rstmid_word got=%h exp=%h", g, e); end
    end
    got_wr.delete();
  endtask

  task automatic test_protocol();
    n_tests++;
    if (proto_err != 0) begin n_fail++; $display("FAIL proto_rd_vs_wr got=%0d exp=0", proto_err); end
    n_tests++;
    if (setup_bad != 0) begin n_fail++; $display("FAIL proto_setup_hold got=%0d exp=0", setup_bad); end
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_burst_write();
    test_read_burst();
    test_txe_stall();
    test_timeout();
    test_reset_mid_strobe();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
